// File: rtl/pwm_analyzer_pkg.sv
// rtl/pwm_analyzer_pkg.sv - shared encodings for the multi-channel PWM analyzer
package pwm_analyzer_pkg;

  typedef enum logic [1:0] {
    CLS_LOW   = 2'b00,
    CLS_MID   = 2'b01,
    CLS_HIGH  = 2'b10,
    CLS_FAULT = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'b00,
    MEASURE   = 2'b01,
    FAULT_ST  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_STUCK = 2'b01,
    CAUSE_LOST  = 2'b10
  } cause_e;

endpackage

// File: rtl/pwm_channel_meter.sv
// rtl/pwm_channel_meter.sv - one PWM channel: synchronizer, edge detect, width FSM,
// timeout, and hysteretic classifier
module pwm_channel_meter
  import pwm_analyzer_pkg::*;
#(
  parameter int CNT_W     = 11,
  parameter int MAX_COUNT = 2000,
  parameter int HIGH_TH   = 1900,
  parameter int LOW_TH    = 1100,
  parameter int HYST      = 20,
  parameter int TO_W      = 16,
  parameter int TIMEOUT   = 40000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pwm_in,
  input  logic             ch_en,
  output logic [CNT_W-1:0] width_out,
  output logic             meas_valid,
  output logic [1:0]       class_out,
  output logic             fault
);

  localparam logic [CNT_W:0]   CNT_LIM = (CNT_W+1)'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);
  localparam logic [TO_W:0]    TO_LIM  = (TO_W+1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] HI_IN   = CNT_W'(HIGH_TH);
  localparam logic [CNT_W-1:0] HI_OUT  = CNT_W'(HIGH_TH - HYST);
  localparam logic [CNT_W-1:0] LO_IN   = CNT_W'(LOW_TH);
  localparam logic [CNT_W-1:0] LO_OUT  = CNT_W'(LOW_TH + HYST);

  logic             r_sync1, r_sync2, r_prev;
  state_e           r_state, w_state_nx;
  logic [CNT_W-1:0] r_hcnt, w_hcnt_nx;
  logic [TO_W-1:0]  r_to, w_to_nx;
  logic [CNT_W-1:0] r_width, w_width_nx;
  logic             r_valid, w_valid_nx;
  cls_e             r_cls, w_cls_nx;
  cause_e           r_cause, w_cause_nx;

  logic             w_en, w_rise, w_fall;
  logic [CNT_W:0]   w_hcnt_inc;
  logic [TO_W:0]    w_to_inc;

  // A class is left only once the width moves past its band by HYST.
  function automatic cls_e classify(input cls_e cur, input logic [CNT_W-1:0] w);
    if (cur == CLS_HIGH && w >= HI_OUT) return CLS_HIGH;
    if (cur == CLS_LOW && w <= LO_OUT)  return CLS_LOW;
    if (w >= HI_IN)                     return CLS_HIGH;
    if (w <= LO_IN)                     return CLS_LOW;
    return CLS_MID;
  endfunction

  assign w_en       = ena & ch_en;
  assign w_rise     = r_sync2 & ~r_prev;
  assign w_fall     = ~r_sync2 & r_prev;
  assign w_hcnt_inc = {1'b0, r_hcnt} + (CNT_W+1)'(1);
  assign w_to_inc   = {1'b0, r_to} + (TO_W+1)'(1);

  always_comb begin
    w_state_nx = r_state;
    w_hcnt_nx  = r_hcnt;
    w_to_nx    = r_to;
    w_width_nx = r_width;
    w_valid_nx = 1'b0;
    w_cls_nx   = r_cls;
    w_cause_nx = r_cause;
    if (w_en) begin
      case (r_state)
        WAIT_RISE: begin
          if (w_rise) begin
            w_state_nx = MEASURE;
            w_hcnt_nx  = CNT_W'(1);
            w_to_nx    = '0;
          end else if (w_to_inc >= TO_LIM) begin
            w_state_nx = FAULT_ST;
            w_cls_nx   = CLS_FAULT;
            w_cause_nx = CAUSE_LOST;
          end else begin
            w_to_nx = w_to_inc[TO_W-1:0];
          end
        end
        MEASURE: begin
          if (w_fall) begin
            w_state_nx = WAIT_RISE;
            w_width_nx = r_hcnt;
            w_valid_nx = 1'b1;
            w_cls_nx   = classify(r_cls, r_hcnt);
            w_to_nx    = '0;
          end else if (w_hcnt_inc >= CNT_LIM) begin
            w_state_nx = FAULT_ST;
            w_hcnt_nx  = CNT_MAX;
            w_width_nx = CNT_MAX;
            w_cls_nx   = CLS_FAULT;
            w_cause_nx = CAUSE_STUCK;
          end else begin
            w_hcnt_nx = w_hcnt_inc[CNT_W-1:0];
          end
        end
        FAULT_ST: begin
          if (w_rise) begin
            w_state_nx = MEASURE;
            w_hcnt_nx  = CNT_W'(1);
          end
        end
        default: w_state_nx = WAIT_RISE;
      endcase
    end
  end

  // The edge-detect register runs even while held, so edges during a hold are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_state <= WAIT_RISE;
      r_hcnt  <= '0;
      r_to    <= '0;
      r_width <= '0;
      r_valid <= 1'b0;
      r_cls   <= CLS_MID;
      r_cause <= CAUSE_NONE;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_state_nx;
      r_hcnt  <= w_hcnt_nx;
      r_to    <= w_to_nx;
      r_width <= w_width_nx;
      r_valid <= w_valid_nx;
      r_cls   <= w_cls_nx;
      r_cause <= w_cause_nx;
    end
  end

  assign width_out  = r_width;
  assign meas_valid = r_valid;
  assign class_out  = r_cls;
  assign fault      = (r_cause != CAUSE_NONE);

endmodule

// File: rtl/pwm_multi_analyzer.sv
// rtl/pwm_multi_analyzer.sv - N_CH independent PWM width analyzers with
// concatenated result buses and a combined fault flag
module pwm_multi_analyzer
  import pwm_analyzer_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 11,
  parameter int MAX_COUNT = 2000,
  parameter int HIGH_TH   = 1900,
  parameter int LOW_TH    = 1100,
  parameter int HYST      = 20,
  parameter int TO_W      = 16,
  parameter int TIMEOUT   = 40000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [N_CH-1:0]       pwm_in,
  input  logic [N_CH-1:0]       ch_en,
  output logic [N_CH*CNT_W-1:0] width_out,
  output logic [N_CH-1:0]       meas_valid,
  output logic [2*N_CH-1:0]     class_out,
  output logic [N_CH-1:0]       fault,
  output logic                  any_fault
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      pwm_channel_meter #(
        .CNT_W    (CNT_W),
        .MAX_COUNT(MAX_COUNT),
        .HIGH_TH  (HIGH_TH),
        .LOW_TH   (LOW_TH),
        .HYST     (HYST),
        .TO_W     (TO_W),
        .TIMEOUT  (TIMEOUT)
      ) u_meter (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .pwm_in    (pwm_in[gi]),
        .ch_en     (ch_en[gi]),
        .width_out (width_out[gi*CNT_W +: CNT_W]),
        .meas_valid(meas_valid[gi]),
        .class_out (class_out[2*gi +: 2]),
        .fault     (fault[gi])
      );
    end
  endgenerate

  assign any_fault = |fault;

endmodule

// File: tb/tb_pwm_multi_analyzer.sv
// tb/tb_pwm_multi_analyzer.sv - scoreboard bench for pwm_multi_analyzer
module tb_pwm_multi_analyzer;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  pwm_in;
  logic [3:0]  ch_en;
  logic [43:0] width_out;
  logic [3:0]  meas_valid;
  logic [7:0]  class_out;
  logic [3:0]  fault;
  logic        any_fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ch;
    int         w;
    logic [1:0] c;
  } exp_t;
  exp_t sb[$];

  localparam logic [1:0] LOW = 2'b00, MID = 2'b01, HIGH = 2'b10, FLT = 2'b11;

  pwm_multi_analyzer dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .pwm_in    (pwm_in),
    .ch_en     (ch_en),
    .width_out (width_out),
    .meas_valid(meas_valid),
    .class_out (class_out),
    .fault     (fault),
    .any_fault (any_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every strobe must match the oldest pending expectation of its channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (meas_valid[i]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].ch == i) idx = k;
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL unexpected_strobe ch%0d width=%0d class=%b", i, width_out[i*11 +: 11], class_out[2*i +: 2]);
          end else begin
            if (width_out[i*11 +: 11] !== 11'(sb[idx].w)) begin
              bad++;
              $display("FAIL width ch%0d got=%0d want=%0d", i, width_out[i*11 +: 11], sb[idx].w);
            end
            total++;
            if (class_out[2*i +: 2] !== sb[idx].c) begin
              bad++;
              $display("FAIL class ch%0d got=%b want=%b", i, class_out[2*i +: 2], sb[idx].c);
            end
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst    = 1'b1;
    ena    = 1'b1;
    ch_en  = 4'hF;
    pwm_in = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse(input int ch, input int len);
    pwm_in[ch] = 1'b1;
    repeat (len) @(posedge clk);
    #1 pwm_in[ch] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int ch, input int w, input logic [1:0] c);
    exp_t e;
    e.ch = ch;
    e.w  = w;
    e.c  = c;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (width_out !== 44'h0) begin bad++; $display("FAIL rst_width got=%h want=0", width_out); end
    total++;
    if (meas_valid !== 4'h0) begin bad++; $display("FAIL rst_valid got=%b want=0000", meas_valid); end
    total++;
    if (class_out !== 8'h55) begin bad++; $display("FAIL rst_class got=%h want=55", class_out); end
    total++;
    if (fault !== 4'h0) begin bad++; $display("FAIL rst_fault got=%b want=0000", fault); end
    total++;
    if (any_fault !== 1'b0) begin bad++; $display("FAIL rst_any_fault got=%b want=0", any_fault); end
  endtask

  task automatic test_single();
    do_reset();
    push(0, 1500, MID);
    pulse(0, 1500);
    drain();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL single_drain left=%0d want=0", sb.size()); sb.delete(); end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (width_out[i*11 +: 11] !== 11'd0) begin
        bad++; $display("FAIL single_other ch%0d got=%0d want=0", i, width_out[i*11 +: 11]);
      end
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    push(1, 1950, HIGH);
    push(1, 1890, HIGH);
    push(1, 1870, MID);
    pulse(1, 1950);
    repeat (20) @(posedge clk);
    #1 pulse(1, 1890);
    repeat (20) @(posedge clk);
    #1 pulse(1, 1870);
    drain();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL hyst_drain left=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_stuck();
    do_reset();
    pulse(2, 2100);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (class_out[5:4] !== FLT) begin bad++; $display("FAIL stuck_class got=%b want=11", class_out[5:4]); end
    total++;
    if (fault[2] !== 1'b1) begin bad++; $display("FAIL stuck_fault got=%b want=1", fault[2]); end
    total++;
    if (any_fault !== 1'b1) begin bad++; $display("FAIL stuck_any got=%b want=1", any_fault); end
    total++;
    if (width_out[32:22] !== 11'd2000) begin bad++; $display("FAIL stuck_width got=%0d want=2000", width_out[32:22]); end
    push(2, 1000, LOW);
    pulse(2, 1000);
    drain();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL stuck_drain left=%0d want=0", sb.size()); sb.delete(); end
    total++;
    if (fault[2] !== 1'b1) begin bad++; $display("FAIL stuck_sticky got=%b want=1", fault[2]); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (39999) @(posedge clk);
    #1;
    total++;
    if (fault[3] !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", fault[3]); end
    @(posedge clk);
    #1;
    total++;
    if (fault[3] !== 1'b1) begin bad++; $display("FAIL to_fault got=%b want=1", fault[3]); end
    total++;
    if (class_out[7:6] !== FLT) begin bad++; $display("FAIL to_class got=%b want=11", class_out[7:6]); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] mv;
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 1000, LOW);
    pwm_in = 4'hF;
    repeat (1000) @(posedge clk);
    #1 pwm_in = 4'h0;
    mv = 4'h0;
    for (int n = 0; n < 20 && mv == 4'h0; n++) begin
      @(posedge clk);
      #1 mv = meas_valid;
    end
    total++;
    if (mv !== 4'hF) begin bad++; $display("FAIL simul_strobes got=%b want=1111", mv); end
    drain();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL simul_drain left=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_hold_and_reset();
    logic seen;
    do_reset();
    push(0, 1400, MID);
    pwm_in[0] = 1'b1;
    repeat (500) @(posedge clk);
    #1 ch_en[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1 ch_en[0] = 1'b1;
    repeat (900) @(posedge clk);
    #1 pwm_in[0] = 1'b0;
    drain();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL hold_drain left=%0d want=0", sb.size()); sb.delete(); end

    pwm_in[0] = 1'b1;
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 pwm_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1 if (meas_valid != 4'h0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrst_strobe got=%b want=0", seen); end
    total++;
    if (width_out !== 44'h0) begin bad++; $display("FAIL midrst_width got=%h want=0", width_out); end
    total++;
    if (class_out !== 8'h55) begin bad++; $display("FAIL midrst_class got=%h want=55", class_out); end
    total++;
    if (fault !== 4'h0) begin bad++; $display("FAIL midrst_fault got=%b want=0000", fault); end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    ch_en  = 4'hF;
    pwm_in = 4'h0;
    test_reset();
    test_single();
    test_hysteresis();
    test_stuck();
    test_timeout();
    test_simultaneous();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
